random_arbiter: RTL and testbench

Round-robin scheduler that shares one multi-stream random number generator between NREQ requesters. Each requester owns one RNG stream. For each grant the block programs the stream register (skipped when already selected), reads the output register, then issues the generate-next write. It sits between client logic and the RNG's slave bus as that port's only master, and delivers one 32-bit value per grant.

---
 rtl/random_arbiter.sv | 169 ++++++++++++++++
 tb/tb_random_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_arbiter.sv
// Round-robin front end that shares one multi-stream RNG between NREQ clients.
// Each grant selects the client's stream, reads one value, then advances that stream.
module random_arbiter #(
  parameter int          NREQ        = 4,
  parameter logic [31:0] IO_ADDR     = 32'hFEE10000,
  parameter logic [9:0]  STREAM_BASE = 10'd0,
  parameter int          WR_GAP      = 3,
  parameter int          TIMEOUT     = 63
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [31:0]     dat_o,
  output logic            err_o,
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic            m_we_o,
  output logic [31:0]     m_adr_o,
  output logic [31:0]     m_dat_o,
  input  logic            m_ack_i,
  input  logic [31:0]     m_dat_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WSTREAM = 3'd1;
  localparam logic [2:0] S_WGAP1   = 3'd2;
  localparam logic [2:0] S_RD      = 3'd3;
  localparam logic [2:0] S_WNEXT   = 3'd4;
  localparam logic [2:0] S_WGAP2   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic          cache_vld;
  logic [9:0]    cache_stream;
  logic [15:0]   cnt;
  logic [31:0]   cap;
  logic [IW:0]   pick;
  logic [9:0]    pick_stream;

  // Nearest requester after 'from' (cyclic); MSB flags that one was found.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] req,
                                          input logic [IW-1:0]   from);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(from) + k) % NREQ);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [9:0] stream_of(input logic [IW-1:0] r);
    return STREAM_BASE + 10'(r);
  endfunction

  assign pick        = rr_pick(req_i, last);
  assign pick_stream = stream_of(pick[IW-1:0]);
  assign m_stb_o     = m_cyc_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      last         <= IW'(NREQ - 1);
      winner       <= '0;
      cache_vld    <= 1'b0;
      cache_stream <= '0;
      cnt          <= '0;
      gnt_o        <= '0;
      dat_o        <= '0;
      err_o        <= 1'b0;
      m_cyc_o      <= 1'b0;
      m_we_o       <= 1'b0;
      m_adr_o      <= '0;
      m_dat_o      <= '0;
    end else begin
      gnt_o <= '0;
      case (state)
        S_IDLE: begin
          if (pick[IW]) begin
            winner  <= pick[IW-1:0];
            last    <= pick[IW-1:0];
            cnt     <= '0;
            m_cyc_o <= 1'b1;
            if (cache_vld && cache_stream == pick_stream) begin
              state   <= S_RD;
              m_we_o  <= 1'b0;
              m_adr_o <= IO_ADDR;
              m_dat_o <= '0;
            end else begin
              state        <= S_WSTREAM;
              m_we_o       <= 1'b1;
              m_adr_o      <= IO_ADDR + 32'd4;
              m_dat_o      <= {22'h0, pick_stream};
              cache_stream <= pick_stream;
              cache_vld    <= 1'b1;
            end
          end
        end
        S_WSTREAM: begin
          state   <= S_WGAP1;
          cnt     <= '0;
          m_cyc_o <= 1'b0;
          m_we_o  <= 1'b0;
          m_adr_o <= '0;
          m_dat_o <= '0;
        end
        // Idle gap lets the RNG's RAM settle the new stream before the read.
        S_WGAP1: begin
          if (cnt == 16'(WR_GAP - 1)) begin
            state   <= S_RD;
            cnt     <= '0;
            m_cyc_o <= 1'b1;
            m_adr_o <= IO_ADDR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RD: begin
          if (m_ack_i) begin
            cap    <= m_dat_i;
            state  <= S_WNEXT;
            m_we_o <= 1'b1;
          end else if (cnt == 16'(TIMEOUT)) begin
            // A stalled read leaves the stream register suspect, so force a rewrite.
            state     <= S_DONE;
            m_cyc_o   <= 1'b0;
            m_adr_o   <= '0;
            cache_vld <= 1'b0;
            gnt_o     <= ONE << winner;
            dat_o     <= '0;
            err_o     <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WNEXT: begin
          state   <= S_WGAP2;
          cnt     <= '0;
          m_cyc_o <= 1'b0;
          m_we_o  <= 1'b0;
          m_adr_o <= '0;
        end
        S_WGAP2: begin
          if (cnt == 16'(WR_GAP - 1)) begin
            state <= S_DONE;
            gnt_o <= ONE << winner;
            dat_o <= cap;
            err_o <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          err_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_random_arbiter.sv
// Scoreboard bench for random_arbiter: RNG bus slave model, round-robin reference
// model producing expected grants, and a monitor that checks each grant pulse.
module tb_random_arbiter;

  localparam int          NREQ = 4;
  localparam logic [31:0] IO   = 32'hFEE10000;
  localparam int          G    = 3;
  localparam int          T    = 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i = 1'b1;
  logic [NREQ-1:0] req_i = '0;
  logic [NREQ-1:0] gnt_o;
  logic [31:0]     dat_o;
  logic            err_o;
  logic            m_cyc_o, m_stb_o, m_we_o;
  logic [31:0]     m_adr_o, m_dat_o;
  logic            m_ack_i = 1'b0;
  logic [31:0]     m_dat_i = '0;

  random_arbiter #(
    .NREQ(NREQ), .IO_ADDR(IO), .STREAM_BASE(10'd0), .WR_GAP(G), .TIMEOUT(T)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .dat_o(dat_o),
    .err_o(err_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
  );

  typedef struct packed {logic [NREQ-1:0] gnt; logic [31:0] dat; logic err;} exp_t;
  typedef struct packed {logic we; logic [31:0] adr; logic [31:0] dat;} txn_t;

  exp_t exp_q[$];
  exp_t mon_e;
  txn_t bus_log[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  // Slave configuration and RNG state
  int          ack_lat  = 3;
  bit          ack_en   = 1'b1;
  bit          noise_en = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_dat = '0;
  int          s_cnt[1024];
  logic [9:0]  s_stream = '0;
  int          rd_cnt = 0;
  int          n_swr = 0, n_wnext = 0, stb_err = 0;

  // Reference model state: last winner, cached stream, per-requester advance count
  int m_last = NREQ - 1;
  bit m_cvld = 1'b0;
  int m_cstream = 0;
  int k[NREQ];

  function automatic logic [31:0] rng_val(input logic [9:0] s, input int n);
    return ((32'(s) + 32'd1) * 32'h9E3779B9) ^ (32'(n) * 32'h85EBCA6B) ^ 32'h5A5A0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // RNG slave: stream select at +4, read value at +0, write to +0 advances the stream
  always @(negedge clk) begin
    if (m_stb_o !== m_cyc_o) stb_err++;
    if (m_cyc_o && m_we_o) begin
      bus_log.push_back('{1'b1, m_adr_o, m_dat_o});
      if (m_adr_o == IO + 32'd4) begin
        s_stream = m_dat_o[9:0];
        n_swr++;
      end else if (m_adr_o == IO) begin
        s_cnt[s_stream]++;
        n_wnext++;
      end
      rd_cnt  = 0;
      m_ack_i = noise_en && ($urandom_range(0, 1) == 1);
    end else if (m_cyc_o) begin
      rd_cnt++;
      if (rd_cnt == 1) bus_log.push_back('{1'b0, m_adr_o, 32'h0});
      m_ack_i = ack_en && (rd_cnt == ack_lat);
      m_dat_i = force_en ? force_dat : rng_val(s_stream, s_cnt[s_stream]);
    end else begin
      rd_cnt  = 0;
      m_ack_i = noise_en && ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: every grant pulse is matched against the next expected response
  always @(negedge clk) begin
    if (gnt_o !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(gnt_o), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("grant_vector", 32'(gnt_o), 32'(mon_e.gnt));
        check("grant_data", dat_o, mon_e.dat);
        check("grant_err", 32'(err_o), 32'(mon_e.err));
      end
    end
  end

  function automatic void model_reset();
    m_last = NREQ - 1;
    m_cvld = 1'b0;
  endfunction

  task automatic model_grant(input int i, input bit ok, output bit miss);
    logic [31:0] v;
    miss = !(m_cvld && m_cstream == i);
    v = ok ? (force_en ? force_dat : rng_val(10'(i), k[i])) : 32'h0;
    exp_q.push_back('{NREQ'(1 << i), v, !ok});
    if (ok) begin
      k[i]++;
      m_cvld = 1'b1;
      m_cstream = i;
    end else begin
      m_cvld = 1'b0;
    end
    m_last = i;
  endtask

  // All requesters in 'set' raise together and each drops on its own grant.
  task automatic run_set(input logic [NREQ-1:0] set, input int lat_l, input bit ok, input bit noise);
    int order[$];
    int idx, misses, oks, lat, got, waited, t0;
    bit miss, first_miss, seen;
    int sw0, nw0;
    misses = 0; oks = 0; first_miss = 1'b0;
    for (int s = 1; s <= NREQ; s++) begin
      idx = (m_last + s) % NREQ;
      if (set[idx]) order.push_back(idx);
    end
    foreach (order[j]) begin
      model_grant(order[j], ok, miss);
      if (j == 0) first_miss = miss;
      misses += int'(miss);
      oks    += int'(ok);
    end
    if (ok) lat = first_miss ? (2 * G + lat_l + 3) : (G + lat_l + 2);
    else    lat = first_miss ? (G + T + 3) : (T + 2);
    ack_lat = lat_l; ack_en = ok; noise_en = noise;
    sw0 = n_swr; nw0 = n_wnext;
    @(posedge clk); #1;
    req_i = set;
    t0 = cyc_n; got = 0; waited = 0; seen = 1'b0;
    while (got < order.size() && waited < 400 * order.size()) begin
      @(negedge clk);
      waited++;
      if (gnt_o != '0) begin
        if (!seen) begin
          check("first_grant_latency", 32'(cyc_n - t0), 32'(lat));
          seen = 1'b1;
        end
        got++;
        req_i = req_i & ~gnt_o;
      end
    end
    check("grant_count", 32'(got), 32'(order.size()));
    if (got < order.size()) begin
      req_i = '0;
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    noise_en = 1'b0;
    check("stream_writes", 32'(n_swr - sw0), 32'(misses));
    check("advance_writes", 32'(n_wnext - nw0), 32'(oks));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt_o), 32'h0);
    check({tag, "_dat"}, dat_o, 32'h0);
    check({tag, "_err"}, 32'(err_o), 32'h0);
    check({tag, "_cyc"}, 32'(m_cyc_o), 32'h0);
    check({tag, "_stb"}, 32'(m_stb_o), 32'h0);
    check({tag, "_we"}, 32'(m_we_o), 32'h0);
    check({tag, "_adr"}, m_adr_o, 32'h0);
    check({tag, "_wdat"}, m_dat_o, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, cnt3;
    bit miss;
    logic [NREQ-1:0] set;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_i = 1'b0;
    model_reset();

    // Requester 2 alone, cache miss, fixed read value
    bus_log.delete();
    force_en = 1'b1; force_dat = 32'hDEADBEEF;
    run_set(4'b0100, 3, 1'b1, 1'b0);
    force_en = 1'b0;
    check("log_size", 32'(bus_log.size()), 32'd3);
    check("log0_we", 32'(bus_log[0].we), 32'd1);
    check("log0_adr", bus_log[0].adr, 32'hFEE10004);
    check("log0_dat", bus_log[0].dat, 32'd2);
    check("log1_we", 32'(bus_log[1].we), 32'd0);
    check("log1_adr", bus_log[1].adr, 32'hFEE10000);
    check("log2_we", 32'(bus_log[2].we), 32'd1);
    check("log2_adr", bus_log[2].adr, 32'hFEE10000);
    check("log2_dat", bus_log[2].dat, 32'd0);

    // Same requester again: cache hit
    run_set(4'b0100, 3, 1'b1, 1'b0);

    // Fresh reset, all four requesting
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    model_reset();
    run_set(4'b1111, 2, 1'b1, 1'b0);

    // Read timeout, then the same requester must rewrite its stream
    run_set(4'b0010, 3, 1'b0, 1'b0);
    run_set(4'b0010, 3, 1'b1, 1'b0);

    // Reset while the read is outstanding
    ack_lat = 5; ack_en = 1'b1;
    @(posedge clk); #1;
    req_i = 4'b0100;
    waited = 0;
    while (!(m_cyc_o && !m_we_o) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("reached_read", 32'(m_cyc_o && !m_we_o), 32'd1);
    rst_i = 1'b1;
    req_i = '0;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst_i = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    run_set(4'b0010, 3, 1'b1, 1'b0);

    // Requester 3 withdraws early; grant still arrives exactly once
    ack_lat = 2; ack_en = 1'b1;
    model_grant(3, 1'b1, miss);
    @(posedge clk); #1;
    req_i = 4'b1000;
    repeat (2) @(posedge clk);
    #1 req_i = '0;
    cnt3 = 0;
    repeat (40) begin
      @(negedge clk);
      if (gnt_o[3]) cnt3++;
    end
    check("withdraw_grants", 32'(cnt3), 32'd1);

    // Randomised phases, every third one repeating the last winner for a hit
    for (int ph = 0; ph < 12; ph++) begin
      if (ph % 3 == 0) set = NREQ'(1 << m_last);
      else             set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_set(set, $urandom_range(1, 6), ($urandom_range(0, 5) != 0), ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("stb_equals_cyc", 32'(stb_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
